// File: rtl/yblock_test_pkg.sv
// yblock_test_pkg: shared FSM states and vector-word field layout for the yblock vector player.
package yblock_test_pkg;
   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SYNC, CHECK, HALT} state_e;
   localparam int EXP_LSB = 0;
   function automatic int vec_word_w(input int in_w, input int out_w);
      return in_w + out_w + 2;
   endfunction
   function automatic int drive_lsb(input int out_w);
      return out_w;
   endfunction
   function automatic int nochk_bit(input int in_w, input int out_w);
      return in_w + out_w;
   endfunction
   function automatic int last_bit(input int in_w, input int out_w);
      return in_w + out_w + 1;
   endfunction
endpackage

// File: rtl/yblock_vector_player_if.sv
// yblock_vector_player_if: load path, run control and status of the vector player.
interface yblock_vector_player_if #(
   parameter int IN_W = 52,
   parameter int OUT_W = 48,
   parameter int AW = 8,
   parameter int SETTLE_W = 8,
   parameter int ERR_W = 16
);
   logic                    load_we;
   logic [AW-1:0]           load_addr;
   logic [IN_W+OUT_W+1:0]   load_data;
   logic [OUT_W-1:0]        cmp_mask;
   logic [SETTLE_W-1:0]     settle;
   logic                    start;
   logic                    abort;
   logic                    stop_on_err;
   logic                    busy;
   logic                    done;
   logic                    pass;
   logic [ERR_W-1:0]        err_count;
   logic                    first_err_valid;
   logic [AW-1:0]           first_err_idx;
   logic [OUT_W-1:0]        first_err_got;
   logic [AW-1:0]           cur_idx;
   modport master (
      output load_we, load_addr, load_data, cmp_mask, settle, start, abort, stop_on_err,
      input  busy, done, pass, err_count, first_err_valid, first_err_idx, first_err_got, cur_idx
   );
   modport slave (
      input  load_we, load_addr, load_data, cmp_mask, settle, start, abort, stop_on_err,
      output busy, done, pass, err_count, first_err_valid, first_err_idx, first_err_got, cur_idx
   );
endinterface

// File: rtl/yblock_vector_mem.sv
// yblock_vector_mem: vector store, synchronous write and asynchronous read.
module yblock_vector_mem #(
   parameter int W = 102,
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/yblock_vector_player.sv
// yblock_vector_player: applies stored vectors to the fabric, waits, compares, logs errors.
module yblock_vector_player
   import yblock_test_pkg::*;
#(
   parameter int IN_W = 52,
   parameter int OUT_W = 48,
   parameter int DEPTH = 256,
   parameter int AW = $clog2(DEPTH),
   parameter int SETTLE_W = 8,
   parameter int ERR_W = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   yblock_vector_player_if.slave bus,
   output logic [IN_W-1:0]  vec_out,
   input  logic [OUT_W-1:0] dut_in
);
   localparam int VW = vec_word_w(IN_W, OUT_W);
   localparam int DRIVE_LSB = drive_lsb(OUT_W);
   localparam int NOCHK_BIT = nochk_bit(IN_W, OUT_W);
   localparam int LAST_BIT = last_bit(IN_W, OUT_W);
   state_e state_q, state_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;
   logic phase_q, phase_d;
   logic [AW-1:0] idx_q, idx_d, fidx_q, fidx_d;
   logic [IN_W-1:0] vec_q, vec_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic fev_q, fev_d, pass_q, pass_d;
   logic [OUT_W-1:0] fgot_q, fgot_d, s1_q, s2_q;
   logic [VW-1:0] word;
   logic busy, mismatch, fin;
   assign busy = state_q != IDLE && state_q != HALT;
   yblock_vector_mem #(.W(VW), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk(wb_clk_i), .we(bus.load_we && !busy), .waddr(bus.load_addr),
      .wdata(bus.load_data), .raddr(idx_q), .rdata(word)
   );
   assign mismatch = !word[NOCHK_BIT] && |((s2_q ^ word[EXP_LSB +: OUT_W]) & bus.cmp_mask);
   assign fin = (mismatch && bus.stop_on_err) || word[LAST_BIT] || idx_q == AW'(DEPTH - 1);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      phase_d = phase_q;
      idx_d = idx_q;
      vec_d = vec_q;
      err_d = err_q;
      fev_d = fev_q;
      fidx_d = fidx_q;
      fgot_d = fgot_q;
      pass_d = pass_q;
      if (bus.abort && busy) begin
         state_d = HALT;
         pass_d = 1'b0;
      end else
         case (state_q)
            IDLE, HALT:
               if (bus.start) begin
                  state_d = APPLY;
                  idx_d = '0;
                  err_d = '0;
                  fev_d = 1'b0;
                  fidx_d = '0;
                  fgot_d = '0;
                  pass_d = 1'b0;
               end
            APPLY: begin
               vec_d = word[DRIVE_LSB +: IN_W];
               cnt_d = bus.settle;
               phase_d = 1'b0;
               state_d = bus.settle == '0 ? SYNC : SETTLE;
            end
            SETTLE: begin
               cnt_d = cnt_q - 1'b1;
               state_d = cnt_q == SETTLE_W'(1) ? SYNC : SETTLE;
            end
            SYNC: begin
               phase_d = !phase_q;
               state_d = phase_q ? CHECK : SYNC;
            end
            CHECK: begin
               if (mismatch) begin
                  err_d = err_q + ERR_W'(err_q != '1);
                  if (!fev_q) begin
                     fev_d = 1'b1;
                     fidx_d = idx_q;
                     fgot_d = s2_q;
                  end
               end
               state_d = fin ? HALT : APPLY;
               idx_d = fin ? idx_q : idx_q + 1'b1;
               pass_d = fin && err_d == '0;
            end
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         cnt_q <= '0;
         phase_q <= 1'b0;
         idx_q <= '0;
         vec_q <= '0;
         err_q <= '0;
         fev_q <= 1'b0;
         fidx_q <= '0;
         fgot_q <= '0;
         pass_q <= 1'b0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         phase_q <= phase_d;
         idx_q <= idx_d;
         vec_q <= vec_d;
         err_q <= err_d;
         fev_q <= fev_d;
         fidx_q <= fidx_d;
         fgot_q <= fgot_d;
         pass_q <= pass_d;
         s1_q <= dut_in;
         s2_q <= s1_q;
      end
   assign vec_out = vec_q;
   assign bus.busy = busy;
   assign bus.done = state_q == HALT;
   assign bus.pass = pass_q;
   assign bus.err_count = err_q;
   assign bus.first_err_valid = fev_q;
   assign bus.first_err_idx = fidx_q;
   assign bus.first_err_got = fgot_q;
   assign bus.cur_idx = idx_q;
endmodule

// File: tb/tb_yblock_vector_player.sv
// tb_yblock_vector_player: scoreboard bench; a fixed XOR fabric model answers vec_out.
module tb_yblock_vector_player;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [47:0] fab(input logic [51:0] dv);
      return dv[47:0] ^ 48'h5A5A_5A5A_5A5A;
   endfunction
   yblock_vector_player_if #(.AW(8)) b0();
   yblock_vector_player_if #(.AW(3), .ERR_W(2)) b1();
   logic [51:0] vec0, vec1;
   logic [47:0] din0, din1;
   assign din0 = fab(vec0);
   assign din1 = fab(vec1);
   yblock_vector_player u0 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(b0.slave), .vec_out(vec0), .dut_in(din0));
   yblock_vector_player #(.DEPTH(8), .ERR_W(2)) u1 (.wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(b1.slave), .vec_out(vec1), .dut_in(din1));
   typedef struct {
      logic pass; logic [15:0] err; logic fev; logic [7:0] fidx;
      logic [47:0] fgot; logic [7:0] cur; int cyc; logic [51:0] vec;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int checks = 0, errors = 0, cyc;
   logic [51:0] d[8];
   task automatic load0(input int a, input logic last, input logic nochk, input logic [51:0] dv, input logic [47:0] x);
      @(negedge clk);
      b0.load_we = 1'b1; b0.load_addr = 8'(a); b0.load_data = {last, nochk, dv, x};
      @(negedge clk);
      b0.load_we = 1'b0;
   endtask
   task automatic run0(input logic with_abort, input logic poke, output int n);
      int t;
      @(negedge clk);
      b0.start = 1'b1; b0.abort = with_abort;
      @(negedge clk);
      b0.start = 1'b0; b0.abort = 1'b0;
      if (poke) begin b0.load_we = 1'b1; b0.load_addr = 8'd1; b0.load_data = '0; end
      n = 0; t = 0;
      while (!b0.done && t < 5000) begin
         if (b0.busy) n++;
         t++;
         @(negedge clk);
         b0.load_we = 1'b0;
      end
      checks++;
      if (!b0.done) begin errors++; $display("FAIL run0_timeout done=%0b want 1", b0.done); end
   endtask
   task automatic test_reset;
      #1;
      checks++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.pass !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%0b done=%0b pass=%0b want 000", b0.busy, b0.done, b0.pass); end
      checks++; if (vec0 !== '0 || b0.cur_idx !== '0 || b0.err_count !== '0) begin errors++; $display("FAIL reset_vals vec=%h cur=%0d err=%0d want 0", vec0, b0.cur_idx, b0.err_count); end
      checks++; if (b0.first_err_valid !== 1'b0 || b0.first_err_got !== '0) begin errors++; $display("FAIL reset_ferr fev=%0b got=%h want 0", b0.first_err_valid, b0.first_err_got); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_pass_run;
      for (int i = 0; i < 4; i++) begin
         d[i] = 52'({$urandom, $urandom});
         load0(i, i == 3, 1'b0, d[i], fab(d[i]));
      end
      b0.settle = 8'd2; b0.cmp_mask = '1; b0.stop_on_err = 1'b0;
      sb.push_back('{1'b1, 16'd0, 1'b0, 8'd0, 48'd0, 8'd3, 24, d[3]});
      run0(1'b0, 1'b0, cyc);
      e = sb.pop_front();
      checks++; if (b0.pass !== e.pass || b0.err_count !== e.err) begin errors++; $display("FAIL pass_run pass=%0b err=%0d want %0b %0d", b0.pass, b0.err_count, e.pass, e.err); end
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL pass_run_busy cycles=%0d want %0d", cyc, e.cyc); end
      checks++; if (b0.cur_idx !== e.cur || vec0 !== e.vec) begin errors++; $display("FAIL pass_run_hold cur=%0d vec=%h want %0d %h", b0.cur_idx, vec0, e.cur, e.vec); end
   endtask
   task automatic test_settle0_start_abort;
      d[0] = 52'h1_2345_6789_ABCD; d[1] = 52'hF_EDCB_A987_6543;
      load0(0, 1'b0, 1'b0, d[0], fab(d[0]));
      load0(1, 1'b1, 1'b0, d[1], fab(d[1]));
      b0.settle = 8'd0;
      sb.push_back('{1'b1, 16'd0, 1'b0, 8'd0, 48'd0, 8'd1, 8, d[1]});
      run0(1'b1, 1'b0, cyc);
      e = sb.pop_front();
      checks++; if (b0.pass !== e.pass || b0.cur_idx !== e.cur) begin errors++; $display("FAIL settle0 pass=%0b cur=%0d want %0b %0d", b0.pass, b0.cur_idx, e.pass, e.cur); end
      checks++; if (cyc != e.cyc) begin errors++; $display("FAIL settle0_busy cycles=%0d want %0d", cyc, e.cyc); end
   endtask
   task automatic test_mismatch;
      for (int i = 0; i < 5; i++) begin
         d[i] = 52'({$urandom, $urandom});
         load0(i, i == 4, 1'b0, d[i], fab(d[i]) ^ (i == 2 ? 48'h20 : 48'h0));
      end
      b0.settle = 8'd2; b0.cmp_mask = '1; b0.stop_on_err = 1'b0;
      sb.push_back('{1'b0, 16'd1, 1'b1, 8'd2, fab(d[2]), 8'd4, 30, d[4]});
      run0(1'b0, 1'b0, cyc);
      e = sb.pop_front();
      checks++; if (b0.err_count !== e.err || b0.pass !== e.pass) begin errors++; $display("FAIL mismatch err=%0d pass=%0b want %0d %0b", b0.err_count, b0.pass, e.err, e.pass); end
      checks++; if (b0.first_err_valid !== e.fev || b0.first_err_idx !== e.fidx) begin errors++; $display("FAIL mismatch_idx fev=%0b idx=%0d want %0b %0d", b0.first_err_valid, b0.first_err_idx, e.fev, e.fidx); end
      checks++; if (b0.first_err_got !== e.fgot) begin errors++; $display("FAIL mismatch_got got=%h want %h", b0.first_err_got, e.fgot); end
      checks++; if (cyc != e.cyc || b0.cur_idx !== e.cur || vec0 !== e.vec) begin errors++; $display("FAIL mismatch_all cycles=%0d cur=%0d want %0d %0d", cyc, b0.cur_idx, e.cyc, e.cur); end
   endtask
   task automatic test_mask_nochk;
      b0.cmp_mask = ~48'h20;
      sb.push_back('{1'b1, 16'd0, 1'b0, 8'd0, 48'd0, 8'd4, 30, d[4]});
      run0(1'b0, 1'b0, cyc);
      e = sb.pop_front();
      checks++; if (b0.pass !== e.pass || b0.err_count !== e.err || b0.first_err_valid !== e.fev) begin errors++; $display("FAIL mask pass=%0b err=%0d fev=%0b want %0b %0d %0b", b0.pass, b0.err_count, b0.first_err_valid, e.pass, e.err, e.fev); end
      b0.cmp_mask = '1;
      load0(2, 1'b0, 1'b1, d[2], fab(d[2]) ^ 48'h20);
      sb.push_back('{1'b1, 16'd0, 1'b0, 8'd0, 48'd0, 8'd4, 30, d[4]});
      run0(1'b0, 1'b0, cyc);
      e = sb.pop_front();
      checks++; if (b0.pass !== e.pass || b0.err_count !== e.err) begin errors++; $display("FAIL nochk pass=%0b err=%0d want %0b %0d", b0.pass, b0.err_count, e.pass, e.err); end
   endtask
   task automatic test_stop;
      for (int i = 0; i < 5; i++) begin
         d[i] = 52'({$urandom, $urandom});
         load0(i, i == 4, 1'b0, d[i], fab(d[i]) ^ ((i == 1 || i == 3) ? 48'h1 : 48'h0));
      end
      b0.stop_on_err = 1'b1;
      sb.push_back('{1'b0, 16'd1, 1'b1, 8'd1, fab(d[1]), 8'd1, 12, d[1]});
      run0(1'b0, 1'b0, cyc);
      e = sb.pop_front();
      b0.stop_on_err = 1'b0;
      checks++; if (b0.cur_idx !== e.cur || b0.err_count !== e.err || b0.pass !== e.pass) begin errors++; $display("FAIL stop cur=%0d err=%0d pass=%0b want %0d %0d %0b", b0.cur_idx, b0.err_count, b0.pass, e.cur, e.err, e.pass); end
      checks++; if (b0.first_err_idx !== e.fidx || b0.first_err_got !== e.fgot || cyc != e.cyc) begin errors++; $display("FAIL stop_cap idx=%0d cycles=%0d want %0d %0d", b0.first_err_idx, cyc, e.fidx, e.cyc); end
   endtask
   task automatic test_abort;
      int t = 0;
      for (int i = 0; i < 4; i++) begin
         d[i] = 52'({$urandom, $urandom});
         load0(i, i == 3, 1'b0, d[i], fab(d[i]));
      end
      b0.settle = 8'd10;
      sb.push_back('{1'b0, 16'd0, 1'b0, 8'd0, 48'd0, 8'd1, 0, d[1]});
      @(negedge clk); b0.start = 1'b1;
      @(negedge clk); b0.start = 1'b0;
      while (b0.cur_idx !== 8'd1 && t < 200) begin t++; @(negedge clk); end
      repeat (3) @(negedge clk);
      b0.abort = 1'b1;
      @(negedge clk); b0.abort = 1'b0;
      e = sb.pop_front();
      checks++; if (b0.done !== 1'b1 || b0.busy !== 1'b0 || b0.pass !== e.pass) begin errors++; $display("FAIL abort done=%0b busy=%0b pass=%0b want 1 0 %0b", b0.done, b0.busy, b0.pass, e.pass); end
      checks++; if (b0.cur_idx !== e.cur || vec0 !== e.vec) begin errors++; $display("FAIL abort_hold cur=%0d vec=%h want %0d %h", b0.cur_idx, vec0, e.cur, e.vec); end
      b0.settle = 8'd2;
      sb.push_back('{1'b1, 16'd0, 1'b0, 8'd0, 48'd0, 8'd3, 24, d[3]});
      run0(1'b0, 1'b1, cyc);
      e = sb.pop_front();
      checks++; if (b0.pass !== e.pass || b0.cur_idx !== e.cur || cyc != e.cyc) begin errors++; $display("FAIL rerun pass=%0b cur=%0d cycles=%0d want %0b %0d %0d", b0.pass, b0.cur_idx, cyc, e.pass, e.cur, e.cyc); end
   endtask
   task automatic test_saturation;
      int t = 0;
      for (int i = 0; i < 8; i++) begin
         d[i] = 52'({$urandom, $urandom});
         @(negedge clk);
         b1.load_we = 1'b1; b1.load_addr = 3'(i); b1.load_data = {2'b00, d[i], ~fab(d[i])};
      end
      @(negedge clk); b1.load_we = 1'b0;
      b1.settle = 8'd2; b1.cmp_mask = '1; b1.stop_on_err = 1'b0;
      sb.push_back('{1'b0, 16'd3, 1'b1, 8'd0, fab(d[0]), 8'd7, 48, d[7]});
      @(negedge clk); b1.start = 1'b1;
      @(negedge clk); b1.start = 1'b0;
      cyc = 0;
      while (!b1.done && t < 1000) begin if (b1.busy) cyc++; t++; @(negedge clk); end
      e = sb.pop_front();
      checks++; if (b1.err_count !== e.err[1:0] || b1.cur_idx !== e.cur[2:0]) begin errors++; $display("FAIL sat err=%0d cur=%0d want %0d %0d", b1.err_count, b1.cur_idx, e.err, e.cur); end
      checks++; if (b1.done !== 1'b1 || b1.pass !== e.pass || cyc != e.cyc) begin errors++; $display("FAIL sat_end done=%0b pass=%0b cycles=%0d want 1 %0b %0d", b1.done, b1.pass, cyc, e.pass, e.cyc); end
      checks++; if (b1.first_err_idx !== e.fidx[2:0] || b1.first_err_got !== e.fgot) begin errors++; $display("FAIL sat_first idx=%0d got=%h want %0d %h", b1.first_err_idx, b1.first_err_got, e.fidx, e.fgot); end
   endtask
   task automatic test_reset_mid;
      @(negedge clk); b0.start = 1'b1;
      @(negedge clk); b0.start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (b0.busy !== 1'b0 || b0.done !== 1'b0 || vec0 !== '0 || b0.cur_idx !== '0) begin errors++; $display("FAIL reset_mid busy=%0b done=%0b vec=%h cur=%0d want 0", b0.busy, b0.done, vec0, b0.cur_idx); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (b0.busy !== 1'b0 || b0.done !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%0b done=%0b want 0 0", b0.busy, b0.done); end
   endtask
   initial begin
      {b0.load_we, b0.start, b0.abort, b0.stop_on_err} = '0;
      b0.load_addr = '0; b0.load_data = '0; b0.cmp_mask = '1; b0.settle = 8'd2;
      {b1.load_we, b1.start, b1.abort, b1.stop_on_err} = '0;
      b1.load_addr = '0; b1.load_data = '0; b1.cmp_mask = '1; b1.settle = 8'd2;
      test_reset;
      test_pass_run;
      test_settle0_start_abort;
      test_mismatch;
      test_mask_nochk;
      test_stop;
      test_abort;
      test_saturation;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
